// File: rtl/qam_symbol_scheduler.sv
// QAM symbol scheduler: frames a fixed preamble followed by payload nibbles
// (low nibble first) on a fixed symbol-slot grid, fed through a 2-byte FIFO.
module qam_symbol_scheduler #(
  parameter int unsigned SYMBOL_PERIOD   = 16,
  parameter int unsigned PREAMBLE_LEN    = 8,
  parameter logic [3:0]  PREAMBLE_SYMBOL = 4'b0101
) (
  input  logic       ipClk,
  input  logic       nReset,
  input  logic       ipFrameStart,
  input  logic [7:0] ipFrameLen,
  input  logic [7:0] ipData,
  input  logic       ipDataValid,
  output logic       opDataReady,
  output logic [3:0] opQAMBlock,
  output logic       opQAMBlockValid,
  output logic       opBusy,
  output logic       opUnderrun,
  output logic       opFrameDone
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DONE} stateT;

  stateT      state, nextState;
  logic [7:0] slotCnt, preCnt, frameLen, remainCnt, acceptCnt;
  logic [7:0] fifoMem [2];
  logic       rdPtr, wrPtr, nibbleHi;
  logic [1:0] occ, occNext;
  logic [7:0] acceptNext, lenNext, headByte;
  logic       slotHit, push, pop, emit, underrun, readyNext;
  logic [3:0] emitSym;

  always_ff @(posedge ipClk) begin
    if (nReset) state <= IDLE;
    else        state <= nextState;
  end

  // The slot action is taken on the edge that leaves a slot-0 cycle, so its
  // registered strobe lands one cycle after the slot counter reads 0.
  always_comb begin
    nextState = state;
    emit      = 1'b0;
    emitSym   = '0;
    underrun  = 1'b0;
    pop       = 1'b0;
    slotHit   = (slotCnt == '0);
    headByte  = fifoMem[rdPtr];
    push      = ipDataValid && opDataReady;
    case (state)
      IDLE: if (ipFrameStart) nextState = PREAMBLE;
      PREAMBLE: if (slotHit) begin
        emit    = 1'b1;
        emitSym = PREAMBLE_SYMBOL;
        if (preCnt == 8'(PREAMBLE_LEN - 1))
          nextState = (frameLen == '0) ? DONE : PAYLOAD;
      end
      PAYLOAD: if (slotHit) begin
        if (occ == '0) underrun = 1'b1;
        else begin
          emit    = 1'b1;
          emitSym = nibbleHi ? headByte[7:4] : headByte[3:0];
          if (nibbleHi) begin
            pop = 1'b1;
            if (remainCnt == 8'd1) nextState = DONE;
          end
        end
      end
      DONE: nextState = IDLE;
    endcase
    occNext    = occ + 2'(push) - 2'(pop);
    acceptNext = (state == IDLE) ? '0 : acceptCnt + 8'(push);
    lenNext    = (state == IDLE && ipFrameStart) ? ipFrameLen : frameLen;
    readyNext  = (nextState == PREAMBLE || nextState == PAYLOAD) &&
                 (occNext < 2'd2) && (acceptNext < lenNext);
  end

  always_ff @(posedge ipClk) begin
    if (nReset) begin
      slotCnt         <= '0;
      preCnt          <= '0;
      frameLen        <= '0;
      remainCnt       <= '0;
      acceptCnt       <= '0;
      rdPtr           <= 1'b0;
      wrPtr           <= 1'b0;
      occ             <= '0;
      nibbleHi        <= 1'b0;
      opDataReady     <= 1'b0;
      opQAMBlock      <= '0;
      opQAMBlockValid <= 1'b0;
      opBusy          <= 1'b0;
      opUnderrun      <= 1'b0;
      opFrameDone     <= 1'b0;
    end else begin
      opQAMBlockValid <= emit;
      opQAMBlock      <= emitSym;
      opUnderrun      <= underrun;
      opFrameDone     <= (state == DONE);
      opBusy          <= (nextState != IDLE);
      opDataReady     <= readyNext;
      acceptCnt       <= acceptNext;
      if (state == IDLE) begin
        slotCnt  <= '0;
        preCnt   <= '0;
        rdPtr    <= 1'b0;
        wrPtr    <= 1'b0;
        occ      <= '0;
        nibbleHi <= 1'b0;
        if (ipFrameStart) begin
          frameLen  <= ipFrameLen;
          remainCnt <= ipFrameLen;
        end
      end else begin
        slotCnt <= (slotCnt == 8'(SYMBOL_PERIOD - 1)) ? '0 : slotCnt + 8'd1;
        if (state == PREAMBLE && slotHit) preCnt <= preCnt + 8'd1;
        if (push) begin
          fifoMem[wrPtr] <= ipData;
          wrPtr          <= ~wrPtr;
        end
        if (pop) begin
          rdPtr     <= ~rdPtr;
          remainCnt <= remainCnt - 8'd1;
        end
        if (emit && state == PAYLOAD) nibbleHi <= ~nibbleHi;
        occ <= occNext;
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Scoreboard bench for qam_symbol_scheduler: a slot-grid reference model
// queues expected strobes/underruns/done pulses, a monitor pops and compares.
module tb_qam_symbol_scheduler;
  localparam int P = 16;
  localparam int L = 8;
  localparam logic [3:0] PSYM = 4'b0101;

  logic       ipClk = 1'b0;
  logic       nReset = 1'b1;
  logic       ipFrameStart = 1'b0;
  logic [7:0] ipFrameLen = '0;
  logic [7:0] ipData = '0;
  logic       ipDataValid = 1'b0;
  logic       opDataReady, opQAMBlockValid, opBusy, opUnderrun, opFrameDone;
  logic [3:0] opQAMBlock;

  always #5 ipClk = ~ipClk;

  qam_symbol_scheduler #(
    .SYMBOL_PERIOD(P),
    .PREAMBLE_LEN(L),
    .PREAMBLE_SYMBOL(PSYM)
  ) dut (
    .ipClk(ipClk),
    .nReset(nReset),
    .ipFrameStart(ipFrameStart),
    .ipFrameLen(ipFrameLen),
    .ipData(ipData),
    .ipDataValid(ipDataValid),
    .opDataReady(opDataReady),
    .opQAMBlock(opQAMBlock),
    .opQAMBlockValid(opQAMBlockValid),
    .opBusy(opBusy),
    .opUnderrun(opUnderrun),
    .opFrameDone(opFrameDone)
  );

  typedef struct {int kind; int sym; int cyc;} evT;  // kind: 0 symbol, 1 underrun, 2 done
  evT expQ[$];

  int errors = 0, checks = 0;
  int cyc = 0;
  bit mActive = 0, mReady = 0, mBusy = 0;
  int t0 = 0, mLen = 0, acc = 0, popped = 0, nib = 0, lastEdge = -10, idleFrom = 0;
  logic [7:0] tbBytes [256];
  int logSym[$], logCyc[$];
  int doneCyc = -1, underCnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: slot k of a frame started at edge t0 falls on edge t0+1+P*k;
  // a payload nibble can go out only if its byte transferred on an earlier edge.
  always @(posedge ipClk) begin : model
    bit accept;
    int k;
    logic [7:0] b;
    cyc++;
    if (nReset) begin
      mActive = 0; mReady = 0; mBusy = 0;
      expQ.delete();
      idleFrom = cyc + 1;
    end else begin
      accept = ipDataValid && mReady;
      if (!mActive) begin
        if (ipFrameStart && cyc >= idleFrom) begin
          mActive = 1; t0 = cyc; mLen = int'(ipFrameLen);
          acc = 0; popped = 0; nib = 0;
        end
      end else begin
        if ((cyc - t0 - 1) % P == 0) begin
          k = (cyc - t0 - 1) / P;
          if (k < L) begin
            expQ.push_back('{0, int'(PSYM), cyc});
            if (k == L - 1 && mLen == 0) begin
              mActive = 0; lastEdge = cyc; idleFrom = cyc + 2;
              expQ.push_back('{2, 0, cyc + 1});
            end
          end else if (acc > nib / 2) begin
            b = tbBytes[nib / 2];
            expQ.push_back('{0, (nib % 2) ? int'(b[7:4]) : int'(b[3:0]), cyc});
            if (nib % 2) popped++;
            nib++;
            if (nib == 2 * mLen) begin
              mActive = 0; lastEdge = cyc; idleFrom = cyc + 2;
              expQ.push_back('{2, 0, cyc + 1});
            end
          end else begin
            expQ.push_back('{1, 0, cyc});
          end
        end
        if (accept) acc++;
      end
      mBusy  = mActive || (cyc == lastEdge);
      mReady = mActive && (acc - popped) < 2 && acc < mLen;
    end
  end

  always @(negedge ipClk) begin : monitor
    evT e;
    int kind;
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      e = expQ.pop_front();
      checks++; errors++;
      $display("FAIL missedEvent: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
    end
    if (opQAMBlockValid || opUnderrun || opFrameDone) begin
      kind = opQAMBlockValid ? 0 : (opUnderrun ? 1 : 2);
      if (opQAMBlockValid) begin
        logSym.push_back(int'(opQAMBlock));
        logCyc.push_back(cyc);
      end
      if (opUnderrun) underCnt++;
      if (opFrameDone) doneCyc = cyc;
      if (expQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpectedEvent: got kind %0d at cycle %0d expected nothing", kind, cyc);
      end else begin
        e = expQ.pop_front();
        check("eventKind", kind, e.kind);
        check("eventCycle", cyc, e.cyc);
        if (kind == 0) check("symbol", int'(opQAMBlock), e.sym);
      end
    end
    check("opDataReady", int'(opDataReady), int'(mReady));
    check("opBusy", int'(opBusy), int'(mBusy));
  end

  task automatic checkAllZero(input string name);
    check({name, "_QAMBlock"}, int'(opQAMBlock), 0);
    check({name, "_QAMBlockValid"}, int'(opQAMBlockValid), 0);
    check({name, "_DataReady"}, int'(opDataReady), 0);
    check({name, "_Busy"}, int'(opBusy), 0);
    check({name, "_Underrun"}, int'(opUnderrun), 0);
    check({name, "_FrameDone"}, int'(opFrameDone), 0);
  endtask

  // mode 0: source always valid, 1: random valid, 2: withheld until 40 cycles after first payload slot
  task automatic runFrame(input int len, input int mode, input bit fillRand,
                          input bit midStart, input int rstOff);
    int xfer = 0;
    int rel;
    bit finished = 0;
    if (fillRand) for (int i = 0; i < len; i++) tbBytes[i] = 8'($urandom);
    logSym.delete(); logCyc.delete();
    underCnt = 0; doneCyc = -1;
    @(negedge ipClk);
    ipFrameStart = 1'b1;
    ipFrameLen   = 8'(len);
    @(negedge ipClk);
    ipFrameStart = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n > 0) @(negedge ipClk);
      rel = cyc - t0;
      if (!mActive && cyc >= idleFrom && expQ.size() == 0) begin
        finished = 1;
        break;
      end
      if (rstOff > 0 && rel == rstOff + 1) checkAllZero("midReset");
      case (mode)
        0:       ipDataValid = 1'b1;
        1:       ipDataValid = 1'($urandom);
        default: ipDataValid = (rel >= 1 + P * L + 40);
      endcase
      ipData       = (acc < len) ? tbBytes[acc] : 8'($urandom);
      ipFrameStart = midStart && (rel == 40);
      nReset       = (rstOff > 0 && rel == rstOff);
      if (!nReset && ipDataValid && opDataReady) xfer++;
    end
    ipDataValid  = 1'b0;
    ipFrameStart = 1'b0;
    nReset       = 1'b0;
    if (!finished) begin
      checks++; errors++;
      $display("FAIL frameTimeout: got no end of frame expected end within 4000 cycles");
    end
    if (rstOff == 0) check("bytesTransferred", xfer, len);
  endtask

  int exp1 [4] = '{3, 10, 12, 5};

  initial begin
    nReset = 1'b1;
    repeat (3) @(negedge ipClk);
    checkAllZero("reset");
    nReset = 1'b0;
    repeat (2) @(negedge ipClk);

    tbBytes[0] = 8'hA3;
    tbBytes[1] = 8'h5C;
    runFrame(2, 0, 0, 0, 0);
    check("f1StrobeCount", logSym.size(), 12);
    if (logSym.size() == 12)
      for (int i = 0; i < 12; i++) begin
        check("f1Symbol", logSym[i], (i < 8) ? 5 : exp1[i - 8]);
        check("f1StrobeCycle", logCyc[i] - t0, 1 + P * i);
      end
    check("f1DoneCycle", doneCyc - t0, 178);

    runFrame(0, 0, 1, 0, 0);
    check("f2StrobeCount", logSym.size(), L);
    check("f2DoneCycle", doneCyc - t0, 1 + P * (L - 1) + 1);

    runFrame(1, 2, 1, 0, 0);
    check("f3Underruns", underCnt, 3);
    check("f3StrobeCount", logSym.size(), L + 2);

    runFrame(3, 0, 1, 0, 0);

    runFrame(5, 1, 1, 0, 1 + P * L + 20);
    check("f5NoFrameDone", doneCyc, -1);

    runFrame(3, 0, 1, 1, 0);
    check("f6DoneCycle", doneCyc - t0, 1 + P * (L + 5) + 1);
    repeat (40) @(negedge ipClk);
    check("f6NoSecondFrame", int'(opBusy), 0);

    for (int f = 0; f < 6; f++)
      runFrame(int'($urandom_range(0, 6)), int'($urandom_range(0, 1)), 1, 0, 0);

    repeat (5) @(negedge ipClk);
    check("scoreboardDrained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
